// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one BRAM data port between two masters: port 0 (core load/store)
//   and port 1 (UART program loader). One transaction at a time, round-robin
//   on collisions, one-cycle write strobe, fixed read latency RD_LAT.
//
// Ports
//   clk, rstn          : clock (rising edge), async reset, active-high
//   mX_req/addr/din/we : master X request; we==0 means read
//   mX_dout, mX_done   : master X read data (held) and one-cycle done pulse
//   addr/din/write_enable/dout : BRAM side
//   busy               : high whenever the FSM is not in IDLE
//   grant              : one-hot owner of the current transaction, 00 in IDLE
module mem_port_arbiter #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_din,
  input  logic [DATA_W/8-1:0]   m0_we,
  output logic [DATA_W-1:0]     m0_dout,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_din,
  input  logic [DATA_W/8-1:0]   m1_we,
  output logic [DATA_W-1:0]     m1_dout,
  output logic                  m1_done,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     din,
  output logic [DATA_W/8-1:0]   write_enable,
  input  logic [DATA_W-1:0]     dout,
  output logic                  busy,
  output logic [1:0]            grant
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // index of last granted port
  logic [1:0]          grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [BE_W-1:0]     we_lat_q, we_lat_d;          // latched request type
  logic [BE_W-1:0]     write_enable_q, write_enable_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
  logic                m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic                busy_q, busy_d;
  logic                pick;                        // 1 = port 1 wins in IDLE

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    addr_d         = addr_q;
    din_d          = din_q;
    we_lat_d       = we_lat_q;
    write_enable_d = '0;
    cnt_d          = cnt_q;
    m0_dout_d      = m0_dout_q;
    m1_dout_d      = m1_dout_q;
    m0_done_d      = 1'b0;
    m1_done_d      = 1'b0;
    // On a tie, the port that was not served last wins.
    pick           = m1_req && (!m0_req || !last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          addr_d         = pick ? m1_addr : m0_addr;
          din_d          = pick ? m1_din  : m0_din;
          we_lat_d       = pick ? m1_we   : m0_we;
          // Strobe is registered, so it is loaded now to appear in ISSUE.
          write_enable_d = pick ? m1_we   : m0_we;
          grant_d        = pick ? 2'b10 : 2'b01;
          last_grant_d   = pick;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (we_lat_q != '0) begin
          m0_done_d = grant_q[0];
          m1_done_d = grant_q[1];
          state_d   = DONE;
        end else begin
          // Address is on the BRAM this cycle; count the remaining latency.
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q[0]) m0_dout_d = dout;
          if (grant_q[1]) m1_dout_d = dout;
          m0_done_d = grant_q[0];
          m1_done_d = grant_q[1];
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      grant_q        <= 2'b00;
      addr_q         <= '0;
      din_q          <= '0;
      we_lat_q       <= '0;
      write_enable_q <= '0;
      cnt_q          <= '0;
      m0_dout_q      <= '0;
      m1_dout_q      <= '0;
      m0_done_q      <= 1'b0;
      m1_done_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      we_lat_q       <= we_lat_d;
      write_enable_q <= write_enable_d;
      cnt_q          <= cnt_d;
      m0_dout_q      <= m0_dout_d;
      m1_dout_q      <= m1_dout_d;
      m0_done_q      <= m0_done_d;
      m1_done_q      <= m1_done_d;
      busy_q         <= busy_d;
    end
  end

  assign addr         = addr_q;
  assign din          = din_q;
  assign write_enable = write_enable_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign m0_dout      = m0_dout_q;
  assign m1_dout      = m1_dout_q;
  assign m0_done      = m0_done_q;
  assign m1_done      = m1_done_q;

endmodule
